// File: rtl/lcd_hd44780_rx.sv
// HD44780 4/8-bit bus responder: syncs RS/E/D, assembles bytes, decodes text commands, models busy.
// Latency: decode results register two CLK edges after the first edge that samples E low.
// No backpressure: the driver owns timing; bytes completing while busy still execute and set err_busy.
module lcd_hd44780_rx #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RS,
  input  logic       E,
  input  logic       D4,
  input  logic       D5,
  input  logic       D6,
  input  logic       D7,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       clr,
  output logic       disp_on,
  output logic       four_bit,
  output logic       busy,
  output logic       err_busy
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    PH_HI,
    PH_LO
  } phase_t;

  // synchroniser stages; e_s3 is the previous e_s2 for edge detection
  logic       rs_s1, rs_s2;
  logic       e_s1, e_s2, e_s3;
  logic [3:0] d_s1, d_s2;

  // decode state
  phase_t     phase;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic [6:0] addr;
  logic       id;
  logic [CW-1:0] count;

  logic       e_fall;
  logic       byte_vld;
  logic       byte_rs;
  logic [7:0] byte_dat;
  logic       is_long;

  // two-flop synchroniser on every bus line plus one extra stage on E
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rs_s1 <= 1'b0;
      rs_s2 <= 1'b0;
      e_s1  <= 1'b0;
      e_s2  <= 1'b0;
      e_s3  <= 1'b0;
      d_s1  <= 4'h0;
      d_s2  <= 4'h0;
    end else begin
      rs_s1 <= RS;
      rs_s2 <= rs_s1;
      e_s1  <= E;
      e_s2  <= e_s1;
      e_s3  <= e_s2;
      d_s1  <= {D7, D6, D5, D4};
      d_s2  <= d_s1;
    end
  end

  // byte assembly: 8-bit mode pads the nibble low, 4-bit mode pairs it with the latched high nibble
  always_comb begin
    e_fall   = e_s3 & ~e_s2;
    byte_vld = e_fall & (~four_bit | (phase == PH_LO));
    byte_rs  = four_bit ? hi_rs : rs_s2;
    byte_dat = four_bit ? {hi_nib, d_s2} : {d_s2, 4'h0};
    // clear display and return home take the long busy window
    is_long  = ~byte_rs & (byte_dat[7:2] == 6'b0) & (byte_dat[1:0] != 2'b00);
  end

  assign busy = (count != '0);

  // nibble phase, command/data decode, cursor tracking and busy counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase    <= PH_HI;
      hi_nib   <= 4'h0;
      hi_rs    <= 1'b0;
      addr     <= 7'h00;
      id       <= 1'b1;
      count    <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= 7'h00;
      wr_data  <= 8'h00;
      clr      <= 1'b0;
      disp_on  <= 1'b0;
      four_bit <= 1'b0;
      err_busy <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      clr      <= 1'b0;
      if (count != '0) count <= count - CW'(1);

      // first nibble of a 4-bit transfer: no busy load or check
      if (e_fall && four_bit && (phase == PH_HI)) begin
        hi_nib <= d_s2;
        hi_rs  <= rs_s2;
        phase  <= PH_LO;
      end

      if (byte_vld) begin
        phase <= PH_HI;
        count <= is_long ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES);
        if (count != '0) err_busy <= 1'b1;
        if (byte_rs) begin
          wr_valid <= 1'b1;
          wr_addr  <= addr;
          wr_data  <= byte_dat;
          addr     <= id ? addr + 7'd1 : addr - 7'd1;
        end else begin
          casez (byte_dat)
            8'b1???????: addr <= byte_dat[6:0];
            8'b01??????: ;  // CGRAM address: only the busy window applies
            8'b001?????: begin
              // DL = 0 while in 8-bit mode switches the bus to nibble transfers
              if (!four_bit && !byte_dat[4]) begin
                four_bit <= 1'b1;
                phase    <= PH_HI;
              end
            end
            8'b0001????: ;  // cursor/display shift not modelled
            8'b00001???: disp_on <= byte_dat[2];
            8'b000001??: id <= byte_dat[1];
            8'b0000001?: addr <= 7'h00;
            8'b00000001: begin
              addr <= 7'h00;
              id   <= 1'b1;
              clr  <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Bench for lcd_hd44780_rx: drives the HD44780 bus and checks against a byte-level model.
// Latency: model predicts decode results two CLK edges after the edge that samples E low.
// Backpressure: none; busy violations are predicted from exec timestamps.
module tb_lcd_hd44780_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RS = 1'b0, E = 1'b0, D4 = 1'b0, D5 = 1'b0, D6 = 1'b0, D7 = 1'b0;
  logic       wr_valid, clr, disp_on, four_bit, busy, err_busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  lcd_hd44780_rx #(.BUSY_CYCLES(40), .CLEAR_CYCLES(1600)) dut (
    .CLK(CLK), .RST(RST), .RS(RS), .E(E),
    .D4(D4), .D5(D5), .D6(D6), .D7(D7),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr),
    .disp_on(disp_on), .four_bit(four_bit), .busy(busy), .err_busy(err_busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit         m_four, m_phase, m_id, m_disp, m_err, m_rs;
  logic [3:0] m_hi;
  logic [6:0] m_addr;
  int         m_busy_end;
  int         m_clr;
  int         last_exec;
  logic [14:0] exp_q[$];

  // observed activity
  logic [14:0] got_q[$];
  int          got_clr = 0;
  int          busy_rise = 0;
  int          busy_len = -1;
  logic        busy_q = 1'b0;

  always @(negedge CLK) begin
    if (wr_valid === 1'b1) got_q.push_back({wr_addr, wr_data});
    if (clr === 1'b1) got_clr++;
    if (busy === 1'b1 && busy_q === 1'b0) busy_rise = cyc;
    if (busy === 1'b0 && busy_q === 1'b1) busy_len = cyc - busy_rise;
    busy_q = busy;
  end

  // model: one complete byte executing at CLK edge t
  task automatic m_exec(input bit rs, input logic [7:0] b, input int t);
    if (t <= m_busy_end) m_err = 1'b1;
    m_busy_end = t + ((!rs && b >= 8'd1 && b <= 8'd3) ? 1600 : 40);
    last_exec = t;
    if (rs) begin
      exp_q.push_back({m_addr, b});
      m_addr = m_id ? m_addr + 7'd1 : m_addr - 7'd1;
    end else if (b[7]) m_addr = b[6:0];
    else if (b[6]) ;
    else if (b[5]) begin
      if (!m_four && !b[4]) begin m_four = 1'b1; m_phase = 1'b0; end
    end
    else if (b[4]) ;
    else if (b[3]) m_disp = b[2];
    else if (b[2]) m_id = b[1];
    else if (b[1]) m_addr = 7'h00;
    else if (b[0]) begin m_addr = 7'h00; m_id = 1'b1; m_clr++; end
  endtask

  task automatic send_nib(input bit rs, input logic [3:0] n, input int hold);
    int k;
    @(negedge CLK);
    RS = rs; {D7, D6, D5, D4} = n;
    repeat (3) @(negedge CLK);
    E = 1'b1;
    repeat (3) @(negedge CLK);
    E = 1'b0;
    k = cyc + 1;
    repeat (hold) @(negedge CLK);
    if (!m_four) m_exec(rs, {n, 4'h0}, k + 2);
    else if (!m_phase) begin m_hi = n; m_rs = rs; m_phase = 1'b1; end
    else begin m_phase = 1'b0; m_exec(m_rs, {m_hi, n}, k + 2); end
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b, input int gap);
    send_nib(rs, b[7:4], 3);
    send_nib(rs, b[3:0], gap);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0; E = 1'b0;
    repeat (3) @(negedge CLK);
    m_four = 0; m_phase = 0; m_id = 1; m_disp = 0; m_err = 0; m_rs = 0;
    m_hi = 4'h0; m_addr = 7'h00; m_busy_end = 0; m_clr = 0;
    exp_q.delete(); got_q.delete(); got_clr = 0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({wr_valid, clr, wr_addr, wr_data, disp_on, four_bit, busy, err_busy} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0", {wr_valid, clr, wr_addr, wr_data, disp_on, four_bit, busy, err_busy});
    end
  endtask

  task automatic test_init(input int hold);
    do_reset();
    send_nib(0, 4'h3, hold);
    send_nib(0, 4'h3, hold);
    send_nib(0, 4'h3, hold);
    n_checks++;
    if (four_bit !== 1'b0) begin n_fail++; $display("FAIL init_still_8bit got %b required 0", four_bit); end
    send_nib(0, 4'h2, hold);
    n_checks++;
    if (four_bit !== m_four) begin n_fail++; $display("FAIL init_four_bit got %b required %b", four_bit, m_four); end
    n_checks++;
    if (err_busy !== m_err) begin n_fail++; $display("FAIL init_err_busy hold=%0d got %b required %b", hold, err_busy, m_err); end
    n_checks++;
    if (busy !== (cyc < m_busy_end)) begin n_fail++; $display("FAIL init_busy got %b required %b", busy, cyc < m_busy_end); end
  endtask

  task automatic test_write();
    send_byte(0, 8'hC0, 30);
    send_byte(1, 8'h54, 30);
    send_byte(1, 8'h55, 30);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL write_count got %0d required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL write_%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b0, exp_q[$]}) begin
      n_fail++; $display("FAIL write_hold got %h required %h", {wr_valid, wr_addr, wr_data}, {1'b0, exp_q[$]});
    end
    n_checks++;
    if (err_busy !== m_err) begin n_fail++; $display("FAIL write_err_busy got %b required %b", err_busy, m_err); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_entry_dec();
    send_byte(0, 8'h04, 30);
    send_byte(0, 8'h80, 30);
    send_byte(1, 8'h41, 30);
    send_byte(1, 8'h42, 30);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL entry_count got %0d required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL entry_%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_clear();
    int w;
    repeat (50) @(negedge CLK);
    busy_len = -1;
    send_byte(0, 8'h01, 3);
    w = 0;
    while (busy_len < 0 && w < 3000) begin @(negedge CLK); w++; end
    n_checks++;
    if (busy_len != m_busy_end - last_exec) begin
      n_fail++; $display("FAIL clear_busy_len got %0d required %0d", busy_len, m_busy_end - last_exec);
    end
    n_checks++;
    if (busy_rise != last_exec) begin n_fail++; $display("FAIL clear_busy_rise got %0d required %0d", busy_rise, last_exec); end
    n_checks++;
    if (got_clr != m_clr) begin n_fail++; $display("FAIL clear_pulses got %0d required %0d", got_clr, m_clr); end
    n_checks++;
    if (err_busy !== m_err) begin n_fail++; $display("FAIL clear_err_clean got %b required %b", err_busy, m_err); end
    send_byte(0, 8'h01, 3);
    repeat (100) @(negedge CLK);
    send_byte(1, 8'h5A, 30);
    n_checks++;
    if (err_busy !== m_err) begin n_fail++; $display("FAIL clear_err_busy got %b required %b", err_busy, m_err); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL clear_write_count got %0d required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clear_write_%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (got_clr != m_clr) begin n_fail++; $display("FAIL clear_pulses2 got %0d required %0d", got_clr, m_clr); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_display();
    repeat (50) @(negedge CLK);
    send_byte(0, 8'h0C, 45);
    n_checks++;
    if (disp_on !== m_disp) begin n_fail++; $display("FAIL disp_on_set got %b required %b", disp_on, m_disp); end
    send_byte(0, 8'h08, 45);
    n_checks++;
    if (disp_on !== m_disp) begin n_fail++; $display("FAIL disp_on_clear got %b required %b", disp_on, m_disp); end
  endtask

  task automatic test_reset_mid();
    send_nib(1, 4'h4, 3);
    do_reset();
    send_nib(0, 4'h2, 45);
    n_checks++;
    if (four_bit !== m_four) begin n_fail++; $display("FAIL resetmid_four_bit got %b required %b", four_bit, m_four); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL resetmid_writes got %0d required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    bit         rs;
    logic [7:0] b;
    int         gap;
    do_reset();
    send_nib(0, 4'h3, 45);
    send_nib(0, 4'h3, 45);
    send_nib(0, 4'h3, 45);
    send_nib(0, 4'h2, 45);
    for (int i = 0; i < 120; i++) begin
      rs  = bit'($urandom_range(0, 1));
      b   = 8'($urandom);
      gap = $urandom_range(3, 50);
      send_byte(rs, b, gap);
      n_checks++;
      if ({disp_on, four_bit, err_busy, busy} !== {m_disp, m_four, m_err, cyc < m_busy_end}) begin
        n_fail++;
        $display("FAIL rand_state_%0d byte=%h rs=%b got %b required %b", i, b, rs,
                 {disp_on, four_bit, err_busy, busy}, {m_disp, m_four, m_err, cyc < m_busy_end});
      end
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_write_count got %0d required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_write_%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (got_clr != m_clr) begin n_fail++; $display("FAIL rand_clr_pulses got %0d required %0d", got_clr, m_clr); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init(3);
    test_init(45);
    test_write();
    test_entry_dec();
    test_clear();
    test_display();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_rx.md
# lcd_hd44780_rx

Responder end of the 4-bit HD44780 LCD bus (RS, E, D4–D7) that the name-badge design drives. It emulates the controller side on chip or in the bench: it synchronises the bus, assembles nibbles into bytes, decodes the command set that matters for text output, tracks the DDRAM cursor, and emits one write strobe per displayed character. It also models the busy window, so driver timing violations show up as a sticky error.

## Interface
Parameters:
- BUSY_CYCLES, default 40: CLK cycles of busy after any byte other than clear/home.
- CLEAR_CYCLES, default 1600: CLK cycles of busy after clear display (0x01) or return home (0x02/0x03).

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  asynchronous, active-low reset.
- RS  input  1  register select from the driver: 0 = command, 1 = data.
- E  input  1  enable strobe from the driver; latched on its falling edge.
- D4, D5, D6, D7  input  1 each  bus data nibble; D7 is the MSB.
- wr_valid  output  1  one-cycle strobe: a character was written.
- wr_addr  output  7  DDRAM address of the written character.
- wr_data  output  8  character code.
- clr  output  1  one-cycle strobe: clear display was executed.
- disp_on  output  1  display-on bit (D) from the last display-control command.
- four_bit  output  1  1 once the bus has been switched to 4-bit mode.
- busy  output  1  emulated busy flag.
- err_busy  output  1  sticky: a byte completed while busy was high.

## Operation
- Input sync: RS, E and D4–D7 each pass through two flops (s1, s2). A third flop holds the previous s2 of E. A falling edge is detected when previous s2 = 1 and current s2 = 0. RS and D are taken from the s2 stage in the same cycle.
- Mode after reset is 8-bit (four_bit = 0). Each E fall forms a full byte {D7..D4, 4'b0000}. The byte is executed immediately. The nibble phase stays 0.
- A command byte in 8-bit mode with top bits 001 and bit 4 (DL) = 0 sets four_bit = 1 and clears the nibble phase. Function set with DL = 1 leaves the mode unchanged.
- In 4-bit mode:
  - The first E fall latches the high nibble and RS, and sets phase = 1.
  - The second E fall forms the byte from {high, low} and clears phase.
  - RS is taken from the first nibble.
- Byte decode, command (RS = 0), checked by priority:
  - 1xxxxxxx: addr = byte[6:0].
  - 01xxxxxx: CGRAM address; ignored, only busy is set.
  - 001xxxxx: function set, handled as above.
  - 00001DCB: disp_on = D.
  - 000001IS: id = I. S is ignored.
  - 0000001x: addr = 0.
  - 00000001: addr = 0, id = 1, clr pulse.
  - 00000000: no-op, busy is still set.
- Byte decode, data (RS = 1):
  - wr_valid pulses with wr_addr = addr and wr_data = byte.
  - Then addr = addr + 1 if id = 1, else addr − 1.
  - The address is 7-bit and wraps modulo 128 (0x7F+1 → 0x00, 0x00−1 → 0x7F).
- Busy: every executed byte loads a down-counter with CLEAR_CYCLES (clear/home) or BUSY_CYCLES (all others). busy = (count ≠ 0).
- A byte that completes while busy is high still executes, reloads the counter and sets err_busy. err_busy clears only on reset.
- First nibbles in 4-bit mode neither set busy nor check it.
- Reset values:
  - wr_valid = 0, clr = 0, wr_addr = 0, wr_data = 0.
  - disp_on = 0, four_bit = 0, busy = 0, err_busy = 0.
  - Internal: addr = 0, id = 1, phase = 0, count = 0.
  - All sync flops = 0, so an E that is high at reset release produces no edge until it has been seen high and then low.
- Reset mid-byte discards the pending nibble and returns the bus to 8-bit mode.

## Timing
- Let edge k be the first CLK rising edge that samples E low. Detection is combinational from s2 in cycle k+1. All decode results (wr_valid, clr, addr, disp_on, four_bit, busy load, err_busy) register at edge k+2.
- wr_valid and clr are high for exactly one cycle.
- The driver must hold E high and low for ≥ 3 CLK each. RS and D must be stable from 3 CLK before the E fall to 1 CLK after it. Shorter pulses are unsupported and may be missed.
- busy rises at edge k+2. It falls N cycles later, where N is the loaded count.
- wr_addr and wr_data hold their values between strobes.

## Test plan
- Reset, then E nibble 0x3 (RS = 0) three times and 0x2 once → four_bit = 1 after the 4th fall; err_busy = 1 if the falls are spaced < 40 CLK, else 0.
- In 4-bit mode, send 0x80|0x40 then data 0x54 ('T') → wr_valid for 1 cycle with wr_addr = 0x40 and wr_data = 0x54; addr becomes 0x41.
- Send entry mode 0x04 (I/D = 0), set addr 0x00, write 2 chars → wr_addr = 0x00 then 0x7F.
- Send clear 0x01 → clr for 1 cycle, busy high for exactly 1600 CLK. A data byte sent 100 CLK later sets err_busy and is written at addr 0x00.
- Send 0x0C → disp_on = 1. Send 0x08 → disp_on = 0.
- Pull RST low after only the high nibble in 4-bit mode; release and send nibble 0x2 → it executes as an 8-bit function set (four_bit = 1) with no write strobe.
